// File: rtl/game_multi_target_master_fsm_pkg.sv
// Shared types and helpers for the multi-target game master FSM.
// Holds the state encoding, the lives counter width and a bounded popcount.
package game_master_fsm_pkg;

  localparam int LIVES_WIDTH = 3;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    AIM    = 3'd1,
    SHOOT  = 3'd2,
    RELOAD = 3'd3,
    WON    = 3'd4,
    LOST   = 3'd5
  } state_e;

  // Counts set bits among the low 'width' bits of v (width <= 16).
  function automatic logic [4:0] popcount(input logic [15:0] v, input int unsigned width);
    logic [4:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < width && v[i]) cnt = cnt + 5'd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/game_multi_target_master_fsm_if.sv
// Sprite, collision and timer signals between the game master and the rest of the game.
// Handshake: every strobe is a one-cycle level qualified only by clk; no ready back-pressure exists.
interface game_multi_target_master_fsm_if #(
  parameter int N_TARGETS   = 4,
  parameter int SCORE_WIDTH = 8,
  parameter int LEVEL_WIDTH = 4
);
  import game_master_fsm_pkg::*;

  logic                   launch_key;
  logic [N_TARGETS-1:0]   sprite_target_within_screen;
  logic                   sprite_torpedo_within_screen;
  logic [N_TARGETS-1:0]   collision;
  logic                   end_of_game_timer_running;
  logic [N_TARGETS-1:0]   sprite_target_write_xy;
  logic [N_TARGETS-1:0]   sprite_target_write_dxy;
  logic [N_TARGETS-1:0]   sprite_target_enable_update;
  logic                   sprite_torpedo_write_xy;
  logic                   sprite_torpedo_write_dxy;
  logic                   sprite_torpedo_enable_update;
  logic [N_TARGETS-1:0]   target_alive;
  logic [SCORE_WIDTH-1:0] score;
  logic [LIVES_WIDTH-1:0] lives_left;
  logic [LEVEL_WIDTH-1:0] level;
  logic                   game_won;
  logic                   game_lost;
  logic                   end_of_game_timer_start;
  state_e                 state_dbg;

  modport master (
    input  launch_key, sprite_target_within_screen, sprite_torpedo_within_screen,
           collision, end_of_game_timer_running,
    output sprite_target_write_xy, sprite_target_write_dxy, sprite_target_enable_update,
           sprite_torpedo_write_xy, sprite_torpedo_write_dxy, sprite_torpedo_enable_update,
           target_alive, score, lives_left, level, game_won, game_lost,
           end_of_game_timer_start, state_dbg
  );

  modport slave (
    output launch_key, sprite_target_within_screen, sprite_torpedo_within_screen,
           collision, end_of_game_timer_running,
    input  sprite_target_write_xy, sprite_target_write_dxy, sprite_target_enable_update,
           sprite_torpedo_write_xy, sprite_torpedo_write_dxy, sprite_torpedo_enable_update,
           target_alive, score, lives_left, level, game_won, game_lost,
           end_of_game_timer_start, state_dbg
  );
endinterface

// File: rtl/game_multi_target_master_fsm_rise.sv
// One-flop rising-edge detector; the history flop clears on reset so a level
// already high at reset release shows one rise, which callers gate by state.
module game_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);
  logic in_q;

  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in;
  end

  assign rise = in & ~in_q;
endmodule

// File: rtl/game_multi_target_master_fsm.sv
// Game master for one torpedo against N targets: alive mask, saturating score,
// lives budget, level progression and end-of-game timer handshake.
module game_multi_target_master_fsm
  import game_master_fsm_pkg::*;
#(
  parameter int N_TARGETS   = 4,
  parameter int LIVES       = 3,
  parameter int SCORE_WIDTH = 8,
  parameter int LEVEL_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  game_multi_target_master_fsm_if.master bus
);
  state_e                 state_q, state_d;
  logic [N_TARGETS-1:0]   alive_q, alive_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [LIVES_WIDTH-1:0] lives_q, lives_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   armed_q, armed_d;
  logic [N_TARGETS-1:0]   respawn_q, respawn_d;
  logic                   timer_start_q, timer_start_d;

  logic                   launch_rise;
  logic [N_TARGETS-1:0]   offscreen_rise;
  logic [N_TARGETS-1:0]   hit;
  logic [SCORE_WIDTH+4:0] score_sum;

  game_rise_detect u_launch_rise (
    .clk(clk), .rst(rst), .in(bus.launch_key), .rise(launch_rise)
  );

  for (genvar g = 0; g < N_TARGETS; g++) begin : g_respawn
    game_rise_detect u_offscreen_rise (
      .clk(clk), .rst(rst), .in(~bus.sprite_target_within_screen[g]),
      .rise(offscreen_rise[g])
    );
  end

  assign hit       = bus.collision & alive_q;
  assign score_sum = {5'b0, score_q} + {{SCORE_WIDTH{1'b0}}, popcount(16'(hit), N_TARGETS)};

  always_comb begin
    state_d       = state_q;
    alive_d       = alive_q;
    score_d       = score_q;
    lives_d       = lives_q;
    level_d       = level_q;
    armed_d       = armed_q;
    respawn_d     = '0;
    timer_start_d = 1'b0;
    case (state_q)
      INIT:   state_d = AIM;
      AIM:    if (launch_rise) state_d = SHOOT;
      SHOOT: begin
        // A hit wins over a simultaneous torpedo exit, so no life is lost then.
        if (hit != '0) begin
          alive_d = alive_q & ~hit;
          score_d = (|score_sum[SCORE_WIDTH+4:SCORE_WIDTH]) ? '1 : score_sum[SCORE_WIDTH-1:0];
          if (alive_d == '0) begin
            state_d       = WON;
            timer_start_d = 1'b1;
            if (level_q != '1) level_d = level_q + 1'b1;
          end else begin
            state_d = RELOAD;
          end
        end else if (!bus.sprite_torpedo_within_screen) begin
          lives_d = lives_q - 1'b1;
          if (lives_q == LIVES_WIDTH'(1)) begin
            state_d       = LOST;
            timer_start_d = 1'b1;
          end else begin
            state_d = RELOAD;
          end
        end
      end
      RELOAD: state_d = AIM;
      WON, LOST: begin
        armed_d = armed_q | bus.end_of_game_timer_running;
        if (armed_q && !bus.end_of_game_timer_running) begin
          state_d = INIT;
          armed_d = 1'b0;
          alive_d = '1;
          lives_d = LIVES_WIDTH'(LIVES);
          if (state_q == LOST) begin
            score_d = '0;
            level_d = '0;
          end
        end
      end
      default: state_d = INIT;
    endcase
    if (state_q == AIM || state_q == SHOOT) respawn_d = offscreen_rise & alive_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT;
      alive_q       <= '1;
      score_q       <= '0;
      lives_q       <= LIVES_WIDTH'(LIVES);
      level_q       <= '0;
      armed_q       <= 1'b0;
      respawn_q     <= '0;
      timer_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      alive_q       <= alive_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      armed_q       <= armed_d;
      respawn_q     <= respawn_d;
      timer_start_q <= timer_start_d;
    end
  end

  assign bus.sprite_target_write_xy       = ((state_q == INIT) ? alive_q : '0) | respawn_q;
  assign bus.sprite_target_write_dxy      = ((state_q == INIT) ? alive_q : '0) | respawn_q;
  assign bus.sprite_target_enable_update  = (state_q == AIM || state_q == SHOOT) ? alive_q : '0;
  assign bus.sprite_torpedo_write_xy      = (state_q == INIT) || (state_q == RELOAD);
  assign bus.sprite_torpedo_write_dxy     = (state_q == INIT) || (state_q == RELOAD) ||
                                            ((state_q == AIM) && launch_rise);
  assign bus.sprite_torpedo_enable_update = (state_q == SHOOT);
  assign bus.target_alive                 = alive_q;
  assign bus.score                        = score_q;
  assign bus.lives_left                   = lives_q;
  assign bus.level                        = level_q;
  assign bus.game_won                     = (state_q == WON);
  assign bus.game_lost                    = (state_q == LOST);
  assign bus.end_of_game_timer_start      = timer_start_q;
  assign bus.state_dbg                    = state_q;
endmodule

// File: tb/tb_game_multi_target_master_fsm.sv
// Directed bench for the multi-target game master: scoring, lives, win/lose
// round trips, respawn pulses and launch-key edge handling.
module tb_game_multi_target_master_fsm;
  import game_master_fsm_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  int   timer_pulses = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  game_multi_target_master_fsm_if #(.N_TARGETS(N), .SCORE_WIDTH(8), .LEVEL_WIDTH(4)) bus ();

  game_multi_target_master_fsm #(
    .N_TARGETS(N), .LIVES(3), .SCORE_WIDTH(8), .LEVEL_WIDTH(4)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always @(negedge clk) if (!rst && bus.end_of_game_timer_start) timer_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic press();
    bus.launch_key = 1'b1;
    tick();
    bus.launch_key = 1'b0;
  endtask

  task automatic miss();
    press();
    bus.sprite_torpedo_within_screen = 1'b0;
    tick();
    bus.sprite_torpedo_within_screen = 1'b1;
    settle();
  endtask

  initial begin
    bus.launch_key                   = 1'b0;
    bus.sprite_target_within_screen  = 4'b1111;
    bus.sprite_torpedo_within_screen = 1'b1;
    bus.collision                    = 4'b0000;
    bus.end_of_game_timer_running    = 1'b0;

    // reset state
    tick(); tick(); settle();
    check("rst_state", bus.state_dbg, INIT);
    check("rst_alive", bus.target_alive, 4'b1111);
    check("rst_score", bus.score, 0);
    check("rst_lives", bus.lives_left, 3);
    check("rst_level", bus.level, 0);
    check("rst_won_lost", {bus.game_won, bus.game_lost}, 2'b00);

    // idle after reset: one INIT cycle then AIM
    rst = 1'b0;
    settle();
    check("init_tgt_wxy", bus.sprite_target_write_xy, 4'b1111);
    check("init_tgt_wdxy", bus.sprite_target_write_dxy, 4'b1111);
    check("init_trp_w", {bus.sprite_torpedo_write_xy, bus.sprite_torpedo_write_dxy}, 2'b11);
    tick(); settle();
    check("aim_state", bus.state_dbg, AIM);
    check("aim_tgt_en", bus.sprite_target_enable_update, 4'b1111);
    check("aim_trp_en", bus.sprite_torpedo_enable_update, 0);
    check("aim_trp_wxy", bus.sprite_torpedo_write_xy, 0);
    tick(); tick(); settle();
    check("aim_hold", bus.state_dbg, AIM);

    // launch and a double hit
    bus.launch_key = 1'b1; settle();
    check("launch_dxy", bus.sprite_torpedo_write_dxy, 1);
    tick();
    bus.launch_key = 1'b0; settle();
    check("shoot_state", bus.state_dbg, SHOOT);
    check("shoot_trp_en", bus.sprite_torpedo_enable_update, 1);
    bus.collision = 4'b0101;
    tick();
    bus.collision = 4'b0000; settle();
    exp_q.push_back(8'd2);
    check("hit2_state", bus.state_dbg, RELOAD);
    check("hit2_alive", bus.target_alive, 4'b1010);
    check("hit2_score", bus.score, exp_q.pop_front());
    check("reload_trp_wxy", bus.sprite_torpedo_write_xy, 1);
    tick(); settle();
    check("back_aim", bus.state_dbg, AIM);

    // hit and torpedo exit together: hit counted, no life lost
    press();
    bus.collision = 4'b0010;
    bus.sprite_torpedo_within_screen = 1'b0;
    tick();
    bus.collision = 4'b0000;
    bus.sprite_torpedo_within_screen = 1'b1; settle();
    exp_q.push_back(8'd3);
    check("both_state", bus.state_dbg, RELOAD);
    check("both_score", bus.score, exp_q.pop_front());
    check("both_lives", bus.lives_left, 3);
    check("both_alive", bus.target_alive, 4'b1000);
    tick();

    // collision on a dead target is ignored, then a miss
    press();
    bus.collision = 4'b0001;
    tick();
    bus.collision = 4'b0000; settle();
    check("dead_state", bus.state_dbg, SHOOT);
    check("dead_score", bus.score, 3);
    check("dead_alive", bus.target_alive, 4'b1000);
    bus.sprite_torpedo_within_screen = 1'b0;
    tick();
    bus.sprite_torpedo_within_screen = 1'b1; settle();
    check("miss1_lives", bus.lives_left, 2);
    check("miss1_state", bus.state_dbg, RELOAD);
    tick();

    // respawn of an alive target, none for a dead one
    bus.sprite_target_within_screen = 4'b0111;
    tick(); settle();
    check("respawn_wxy", bus.sprite_target_write_xy, 4'b1000);
    check("respawn_wdxy", bus.sprite_target_write_dxy, 4'b1000);
    bus.sprite_target_within_screen = 4'b1111;
    tick(); settle();
    check("respawn_once", bus.sprite_target_write_xy, 4'b0000);
    bus.sprite_target_within_screen = 4'b1110;
    tick(); settle();
    check("respawn_dead", bus.sprite_target_write_xy, 4'b0000);
    bus.sprite_target_within_screen = 4'b1111;
    tick(); settle();

    // run out of lives
    miss();
    check("miss2_lives", bus.lives_left, 1);
    tick();
    miss();
    check("lost_state", bus.state_dbg, LOST);
    check("lost_flag", bus.game_lost, 1);
    check("lost_lives", bus.lives_left, 0);
    check("lost_tstart", bus.end_of_game_timer_start, 1);
    tick(); settle();
    check("lost_tstart_off", bus.end_of_game_timer_start, 0);
    bus.end_of_game_timer_running = 1'b1;
    repeat (5) tick();
    bus.end_of_game_timer_running = 1'b0; settle();
    check("lost_wait", bus.state_dbg, LOST);
    tick(); settle();
    check("lost_exit_state", bus.state_dbg, INIT);
    check("lost_exit_score", bus.score, 0);
    check("lost_exit_lives", bus.lives_left, 3);
    check("lost_exit_alive", bus.target_alive, 4'b1111);
    check("lost_exit_flag", bus.game_lost, 0);
    tick();

    // clear the wave in two shots
    press();
    bus.collision = 4'b0011;
    tick();
    bus.collision = 4'b0000; settle();
    check("wave1_alive", bus.target_alive, 4'b1100);
    tick();
    press();
    bus.collision = 4'b1100;
    tick();
    bus.collision = 4'b0000; settle();
    exp_q.push_back(8'd4);
    check("won_state", bus.state_dbg, WON);
    check("won_flag", bus.game_won, 1);
    check("won_level", bus.level, 1);
    check("won_score", bus.score, exp_q.pop_front());
    check("won_tstart", bus.end_of_game_timer_start, 1);
    tick(); settle();
    check("won_tstart_off", bus.end_of_game_timer_start, 0);
    bus.end_of_game_timer_running = 1'b1;
    tick();
    bus.end_of_game_timer_running = 1'b0;
    tick(); settle();
    check("won_exit_state", bus.state_dbg, INIT);
    check("won_exit_alive", bus.target_alive, 4'b1111);
    check("won_exit_score", bus.score, 4);
    check("won_exit_level", bus.level, 1);
    check("won_exit_lives", bus.lives_left, 3);
    check("timer_pulses", timer_pulses, 2);
    tick();

    // reset mid-shot with launch key held through reset release
    press();
    bus.launch_key = 1'b1;
    rst = 1'b1;
    tick(); tick(); settle();
    check("midrst_state", bus.state_dbg, INIT);
    check("midrst_score", bus.score, 0);
    check("midrst_level", bus.level, 0);
    rst = 1'b0;
    tick(); settle();
    check("held_aim1", bus.state_dbg, AIM);
    tick(); settle();
    check("held_aim2", bus.state_dbg, AIM);
    bus.launch_key = 1'b0;
    tick();
    bus.launch_key = 1'b1; settle();
    check("repress_dxy", bus.sprite_torpedo_write_dxy, 1);
    tick();
    bus.launch_key = 1'b0; settle();
    check("repress_shoot", bus.state_dbg, SHOOT);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
